// File: rtl/dds_mod_sequencer.sv
// dds_mod_sequencer: symbol-timed LFSR data bit, DDS enable and phase increment.
// Latency start->dds_en 1 clk; config backpressured by cfg_ready (IDLE only, all states with CFG_SHADOW_EN).
// Optional macro CFG_SHADOW_EN: configs taken while running wait in a shadow until the next symbol boundary.
module dds_mod_sequencer #(
  parameter int unsigned SYM_DIV   = 50_000_000,
  parameter logic [4:0]  LFSR_SEED = 5'b00001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_mode,
  input  logic [31:0] cfg_phase_inc0,
  input  logic [31:0] cfg_phase_inc1,
  output logic        dds_en,
  output logic        dds_random,
  output logic [31:0] dds_phase_inc,
  output logic        sym_strobe,
  output logic        busy
);

  localparam int unsigned      CNT_W    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP_WAIT} state_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] inc0;
    logic [31:0] inc1;
  } cfg_t;

  state_t           state;
  logic [CNT_W-1:0] sym_cnt;
  logic [4:0]       lfsr;
  logic [4:0]       lfsr_nxt;
  cfg_t             cfg_act;
  cfg_t             cfg_in;
  cfg_t             cfg_new;
  cfg_t             cfg_bnd;
  logic             cfg_xfer;
  logic             sym_end;

  assign cfg_in   = {cfg_mode, cfg_phase_inc0, cfg_phase_inc1};
  assign cfg_xfer = cfg_valid & cfg_ready;
  assign sym_end  = (sym_cnt == CNT_LAST);
  assign lfsr_nxt = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
  // A config taken on the start edge already drives the first symbol.
  assign cfg_new  = cfg_xfer ? cfg_in : cfg_act;

`ifdef CFG_SHADOW_EN
  cfg_t cfg_shd;
  logic shd_vld;
  assign cfg_bnd = shd_vld ? cfg_shd : cfg_act;
`else
  assign cfg_bnd = cfg_act;
`endif

  function automatic logic map_random(input cfg_t c, input logic b);
    return c.mode[1] ? 1'b1 : b;
  endfunction

  function automatic logic [31:0] map_inc(input cfg_t c, input logic b);
    return (c.mode == 2'd1 && b) ? c.inc1 : c.inc0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sym_cnt       <= '0;
      lfsr          <= LFSR_SEED;
      cfg_act       <= '0;
      dds_en        <= 1'b0;
      dds_random    <= 1'b0;
      dds_phase_inc <= '0;
      sym_strobe    <= 1'b0;
      busy          <= 1'b0;
      cfg_ready     <= 1'b1;
`ifdef CFG_SHADOW_EN
      cfg_shd       <= '0;
      shd_vld       <= 1'b0;
`endif
    end else begin
      sym_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_xfer) cfg_act <= cfg_in;
          if (start) begin
            state         <= RUN;
            sym_cnt       <= '0;
            lfsr          <= LFSR_SEED;
            dds_en        <= 1'b1;
            dds_random    <= map_random(cfg_new, LFSR_SEED[0]);
            dds_phase_inc <= map_inc(cfg_new, LFSR_SEED[0]);
            busy          <= 1'b1;
`ifndef CFG_SHADOW_EN
            cfg_ready     <= 1'b0;
`endif
          end
        end
        RUN, STOP_WAIT: begin
          sym_cnt <= sym_end ? '0 : sym_cnt + CNT_W'(1);
`ifdef CFG_SHADOW_EN
          if (sym_end) begin
            if (shd_vld) cfg_act <= cfg_shd;
            shd_vld <= 1'b0;
          end
          // Taken after the boundary update so a write on that edge waits for the next symbol.
          if (cfg_xfer) begin
            cfg_shd <= cfg_in;
            shd_vld <= 1'b1;
          end
`endif
          // start inside STOP_WAIT cancels the pending stop and keeps the symbol timing.
          if (state == RUN || start) begin
            state <= (state == RUN && stop) ? STOP_WAIT : RUN;
            if (sym_end) begin
              lfsr          <= lfsr_nxt;
              sym_strobe    <= 1'b1;
              dds_random    <= map_random(cfg_bnd, lfsr_nxt[0]);
              dds_phase_inc <= map_inc(cfg_bnd, lfsr_nxt[0]);
            end
          end else if (sym_end) begin
            state         <= IDLE;
            dds_en        <= 1'b0;
            dds_random    <= 1'b0;
            dds_phase_inc <= '0;
            busy          <= 1'b0;
`ifndef CFG_SHADOW_EN
            cfg_ready     <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_mod_sequencer.sv
// Bench for dds_mod_sequencer: randomized scenarios against a symbol-index reference model.
module tb_dds_mod_sequencer;

  localparam int SYM_DIV = 4;
`ifdef CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_phase_inc0;
  logic [31:0] cfg_phase_inc1;
  logic        dds_en;
  logic        dds_random;
  logic [31:0] dds_phase_inc;
  logic        sym_strobe;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit seq[31];

  // Reference model: time since start, run/stop-pending flags, active and shadow config.
  bit          m_run, m_pend, m_shd;
  int          m_t;
  logic [1:0]  m_mode, s_mode;
  logic [31:0] m_i0, m_i1, s_i0, s_i1;

  always #5 clk = ~clk;

  dds_mod_sequencer #(.SYM_DIV(SYM_DIV), .LFSR_SEED(5'b00001)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_phase_inc0(cfg_phase_inc0), .cfg_phase_inc1(cfg_phase_inc1),
    .dds_en(dds_en), .dds_random(dds_random), .dds_phase_inc(dds_phase_inc),
    .sym_strobe(sym_strobe), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_seq();
    bit h[35];
    // h[n+4] is data bit n; four leading zeros are the seed's upper bits.
    for (int i = 0; i < 35; i++) h[i] = 1'b0;
    h[4] = 1'b1;
    for (int n = 0; n < 30; n++) h[n+5] = h[n] ^ h[n+2];
    for (int k = 0; k < 31; k++) seq[k] = h[k+4];
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_mode = 2'd0; cfg_phase_inc0 = '0; cfg_phase_inc1 = '0;
    step(); step();
    reset = 1'b0;
    checks += 5;
    if (dds_en !== 1'b0) begin errors++; $display("FAIL reset dds_en got %b exp 0", dds_en); end
    if (dds_random !== 1'b0) begin errors++; $display("FAIL reset dds_random got %b exp 0", dds_random); end
    if (dds_phase_inc !== 32'h0) begin errors++; $display("FAIL reset dds_phase_inc got %h exp 0", dds_phase_inc); end
    if (sym_strobe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset strobe/busy got %b%b exp 00", sym_strobe, busy); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset cfg_ready got %b exp 1", cfg_ready); end
  endtask

  // Configure, start, then run ncyc edges with optional stop/restart/config events,
  // checking every output against the model after each edge.
  task automatic run_scenario(input string name, input logic [1:0] mode,
                              input logic [31:0] i0, input logic [31:0] i1, input bit same_edge,
                              input int ncyc, input int stop_a, input int stop_b, input int restart_at,
                              input int cfgv_at, input logic [1:0] cv_mode,
                              input logic [31:0] cv_i0, input logic [31:0] cv_i1);
    bit          e_bit, e_rand, e_en, e_str, e_busy, e_rdy, st, sp, acc, was_run;
    logic [31:0] e_inc;
    cfg_mode = mode; cfg_phase_inc0 = i0; cfg_phase_inc1 = i1; cfg_valid = 1'b1;
    if (!same_edge) begin
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL %s idle cfg_ready got %b exp 1", name, cfg_ready); end
      step();
      cfg_valid = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0; cfg_valid = 1'b0;
    m_mode = mode; m_i0 = i0; m_i1 = i1;
    m_run = 1'b1; m_pend = 1'b0; m_shd = 1'b0; m_t = 0;
    for (int c = 0; c <= ncyc; c++) begin
      if (m_run) begin
        e_bit  = seq[(m_t / SYM_DIV) % 31];
        e_en   = 1'b1;
        e_rand = (m_mode >= 2'd2) ? 1'b1 : e_bit;
        e_inc  = (m_mode == 2'd1 && e_bit) ? m_i1 : m_i0;
        e_str  = (m_t > 0) && (m_t % SYM_DIV == 0);
        e_busy = 1'b1;
        e_rdy  = SHADOW;
      end else begin
        e_en = 1'b0; e_rand = 1'b0; e_inc = '0; e_str = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
      end
      checks += 6;
      if (dds_en !== e_en) begin errors++; $display("FAIL %s c=%0d dds_en got %b exp %b", name, c, dds_en, e_en); end
      if (dds_random !== e_rand) begin errors++; $display("FAIL %s c=%0d dds_random got %b exp %b", name, c, dds_random, e_rand); end
      if (dds_phase_inc !== e_inc) begin errors++; $display("FAIL %s c=%0d dds_phase_inc got %h exp %h", name, c, dds_phase_inc, e_inc); end
      if (sym_strobe !== e_str) begin errors++; $display("FAIL %s c=%0d sym_strobe got %b exp %b", name, c, sym_strobe, e_str); end
      if (busy !== e_busy) begin errors++; $display("FAIL %s c=%0d busy got %b exp %b", name, c, busy, e_busy); end
      if (cfg_ready !== e_rdy) begin errors++; $display("FAIL %s c=%0d cfg_ready got %b exp %b", name, c, cfg_ready, e_rdy); end
      if (c == ncyc) break;
      sp = (c == stop_a) || (c == stop_b);
      st = (c == restart_at);
      stop = sp; start = st; cfg_valid = (c == cfgv_at);
      if (c == cfgv_at) begin
        cfg_mode = cv_mode; cfg_phase_inc0 = cv_i0; cfg_phase_inc1 = cv_i1;
      end
      acc = (c == cfgv_at) && (SHADOW || !m_run);
      was_run = m_run;
      step();
      stop = 1'b0; start = 1'b0; cfg_valid = 1'b0;
      if (was_run) begin
        m_t++;
        if ((m_t % SYM_DIV == 0) && m_shd) begin
          m_mode = s_mode; m_i0 = s_i0; m_i1 = s_i1; m_shd = 1'b0;
        end
        if (m_pend && !st && (m_t % SYM_DIV == 0)) m_run = 1'b0;
        else if (m_pend && st) m_pend = 1'b0;
        else if (!m_pend && sp) m_pend = 1'b1;
        if (acc) begin s_mode = cv_mode; s_i0 = cv_i0; s_i1 = cv_i1; m_shd = 1'b1; end
      end else if (acc) begin
        m_mode = cv_mode; m_i0 = cv_i0; m_i1 = cv_i1;
      end
    end
  endtask

  task automatic test_ook();
    run_scenario("ook", 2'd0, 32'h0100_0000, 32'h0, 1'b0, 28, 22, -1, -1, -1, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic test_fsk();
    run_scenario("fsk", 2'd1, 32'h100, 32'h200, 1'b1, 40, 33, -1, -1, -1, 2'd0, 32'h0, 32'h0);
    run_scenario("fsk_rnd", 2'd1, $urandom, $urandom, 1'b0, 40, 30, -1, -1, -1, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic test_stop();
    // Stop seen on the edge leaving sym_cnt=1 of symbol 1; idle after that symbol ends.
    run_scenario("stop", 2'd0, $urandom, $urandom, 1'b0, 12, 5, -1, -1, -1, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic test_stop_cancel();
    run_scenario("stop_cancel", 2'd1, $urandom, $urandom, 1'b0, 30, 5, 17, 6, -1, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic test_carrier();
    run_scenario("carrier", 2'd2, $urandom, $urandom, 1'b1, 130, 124, -1, -1, 10,
                 2'd0, 32'h1234_5678, 32'h0);
  endtask

  task automatic test_cfg_during_run();
    run_scenario("cfg_run", 2'd0, 32'h100, 32'h0, 1'b0, 20, 10, -1, -1, 5,
                 2'd0, 32'h300, 32'h0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int sa, sb, ra, ca;
      sa = $urandom_range(20, 0);
      ca = $urandom_range(sa, 0);
      if ($urandom_range(1, 0) == 1) begin
        ra = sa + 1;
        sb = ra + $urandom_range(5, 1);
      end else begin
        ra = -1;
        sb = -1;
      end
      run_scenario("random", 2'($urandom_range(3, 0)), $urandom, $urandom, 1'($urandom_range(1, 0)),
                   40, sa, sb, ra, ca, 2'($urandom_range(3, 0)), $urandom, $urandom);
    end
  endtask

  task automatic test_reset_mid_run();
    cfg_mode = 2'd1; cfg_phase_inc0 = $urandom; cfg_phase_inc1 = $urandom;
    cfg_valid = 1'b1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks += 4;
    if (dds_en !== 1'b0 || dds_random !== 1'b0) begin errors++; $display("FAIL reset_mid en/random got %b%b exp 00", dds_en, dds_random); end
    if (dds_phase_inc !== 32'h0) begin errors++; $display("FAIL reset_mid dds_phase_inc got %h exp 0", dds_phase_inc); end
    if (sym_strobe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid strobe/busy got %b%b exp 00", sym_strobe, busy); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_mid cfg_ready got %b exp 1", cfg_ready); end
    step();
    checks++;
    if (dds_en !== 1'b0) begin errors++; $display("FAIL reset_mid idle dds_en got %b exp 0", dds_en); end
    run_scenario("after_reset", 2'd0, $urandom, 32'h0, 1'b0, 16, 8, -1, -1, -1, 2'd0, 32'h0, 32'h0);
  endtask

  initial begin
    build_seq();
    test_reset();
    test_ook();
    test_fsk();
    test_stop();
    test_stop_cancel();
    test_carrier();
    test_cfg_during_run();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
